val2_shift_engine: RTL and testbench
====================================

Name: val2_shift_engine

Overview:
- Multi-cycle, parametrised operand-2 generator for the EXE stage. Generalises the combinational val2 path to WIDTH bits.
- Supports rotated immediate, immediate-shifted register, register-shifted register (amount from Rs[7:0]), RRX and memory offset modes.
- Shifts iteratively, STEP bit positions per cycle, behind valid/ready handshakes on both sides. Hazard logic stalls EX while busy.

Parameters:
WIDTH, 32, datapath width (power of 2, >=16)
STEP, 4, max bit positions shifted per SHIFT cycle (power of 2, 1..WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  engine accepts request
rm  in  WIDTH  Rm value
rs  in  WIDTH  Rs value (only [7:0] used)
shift_operand  in  12  instruction bits [11:0]
immd  in  1  I bit
reg_shift  in  1  shift amount from Rs (bit4 of register form)
is_mem_command  in  1  LDR/STR offset mode
c_in  in  1  current CPSR C flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
val2_out  out  WIDTH  operand 2
carry_out  out  1  shifter carry

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, val2_out=0, carry_out=0. Reset mid-SHIFT aborts; no result is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch the operand, amount AMT, kind and c_in.
  - AMT=0: go straight to DONE, so 1-cycle latency.
  - Otherwise go to SHIFT.
- SHIFT: each cycle applies min(STEP, remaining) positions; carry tracks the last bit shifted out. Go to DONE when remaining=0.
  - Latency from accept to out_valid = 1 + ceil(AMT_eff/STEP) cycles.
- DONE: out_valid=1, in_ready=0. val2_out/carry_out stay stable until out_ready=1, then go to IDLE. A new request can be accepted in the cycle after the handshake, never in the same cycle.
- Mode decode (priority order):
  - is_mem_command=1: val2 = zero-extended shift_operand; carry=c_in; AMT=0.
  - immd=1: operand = zero-extended [7:0]; ROR by 2*[11:8].
    - Rotate 0: carry=c_in.
    - Otherwise: carry = result MSB.
  - immd=0, reg_shift=0: type=[6:5], imm5=[11:7].
    - LSL #0: pass Rm, carry=c_in.
    - LSR/ASR #0: mean amount WIDTH.
    - ROR #0: RRX, i.e. {c_in, rm[WIDTH-1:1]}, carry=rm[0], one SHIFT cycle.
  - immd=0, reg_shift=1: A=rs[7:0].
    - A=0: pass Rm, carry=c_in.
    - LSL/LSR with A=WIDTH: result 0, carry=rm[0] (LSL) or rm[WIDTH-1] (LSR).
    - LSL/LSR with A>WIDTH: result 0, carry=0.
    - ASR with A>=WIDTH: all sign bits, carry=sign.
    - ROR: amount A mod WIDTH; if that is 0 and A!=0, result=Rm and carry=rm[WIDTH-1].
  - Saturated cases (A>=WIDTH for LSL/LSR/ASR) finish in one SHIFT cycle (AMT_eff=1), not A/STEP cycles.
- ASR fills with the latched sign bit. ROR wraps modulo WIDTH.
- in_valid while not in IDLE is ignored; the source must hold the request.

Optional Feature:
- Macro: VAL2_ZERO_LATENCY_EN.
- Defined: when AMT_eff<=STEP, the result is computed in the accepting cycle.
  - out_valid is asserted combinationally with the IDLE handshake.
  - State goes directly to DONE only if out_ready=0.
  - That request has 0-cycle latency.
- Undefined: latency exactly as in Behaviour.

Test Plan:
- Mem mode: shift_operand=12'hABC, is_mem_command=1 -> val2_out=32'h00000ABC, carry=c_in, out_valid one cycle after accept.
- Rotated immediate: immd=1, shift_operand=12'h4FF -> ROR 8 -> 32'hFF000000, carry=1, latency 1+2=3 cycles.
- LSR #0 on rm=32'h80000001 -> val2=0, carry=1. ASR #0 on the same value -> 32'hFFFFFFFF, carry=1.
- RRX: rm=32'h00000003, c_in=1 -> val2=32'h80000001, carry=1.
- Register shift edge cases:
  - rs=32 LSL rm=1 -> 0, carry=1.
  - rs=33 LSR -> 0, carry=0.
  - rs=64 ROR rm=32'h80000000 -> val2=rm, carry=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> val2 stable, in_ready=0.
  - Assert rst_n=0 mid-SHIFT -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/val2_shift_engine_if.sv
// rtl/val2_shift_engine_if.sv - request/result handshake bundle for the val2 shift engine
// master drives requests and accepts results; slave is the engine side.
interface val2_shift_engine_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rm;
  logic [WIDTH-1:0] rs;
  logic [11:0]      shift_operand;
  logic             immd;
  logic             reg_shift;
  logic             is_mem_command;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] val2_out;
  logic             carry_out;

  modport master (
    output in_valid, rm, rs, shift_operand, immd, reg_shift, is_mem_command, c_in, out_ready,
    input  in_ready, out_valid, val2_out, carry_out
  );

  modport slave (
    input  in_valid, rm, rs, shift_operand, immd, reg_shift, is_mem_command, c_in, out_ready,
    output in_ready, out_valid, val2_out, carry_out
  );
endinterface

// File: rtl/val2_shift_engine.sv
// rtl/val2_shift_engine.sv - iterative operand-2 shifter, STEP bit positions per cycle
// Optional macro VAL2_ZERO_LATENCY_EN: short shifts complete in the accepting cycle.
module val2_shift_engine #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input logic              clk,
  input logic              rst_n,
  val2_shift_engine_if.slave bus
);
  localparam int LW = $clog2(WIDTH);
  localparam int AW = (LW + 1 > 9) ? LW + 1 : 9;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  typedef enum logic [2:0] {K_NONE, K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] val2_q;
  logic             carry_q;
  logic [WIDTH-1:0] op_q;
  logic [LW-1:0]    rem_q;
  kind_e            kind_q;
  logic             c_q;

  logic [WIDTH-1:0] dec_op;
  kind_e            dec_kind;
  logic [LW-1:0]    dec_amt;
  logic             dec_c;
  logic [AW-1:0]    amt_a;
  logic [4:0]       rot;
  logic [1:0]       sh_type;

  logic [LW-1:0]    step_n;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  logic unused_rs;
  assign unused_rs = ^bus.rs[WIDTH-1:8];

  // One shift of n (1..WIDTH-1) positions; carry is the last bit pushed out.
  function automatic logic [WIDTH:0] shift_step(input kind_e k, input logic [WIDTH-1:0] op,
                                                input logic [LW-1:0] n, input logic c);
    logic [WIDTH-1:0] r;
    logic             co;
    logic [LW-1:0]    lo;
    logic [LW-1:0]    hi;
    r  = op;
    co = c;
    lo = n - LW'(1);
    hi = '0 - n;
    case (k)
      K_LSL:   begin r = op << n;                         co = op[hi]; end
      K_LSR:   begin r = op >> n;                         co = op[lo]; end
      K_ASR:   begin r = $unsigned($signed(op) >>> n);    co = op[lo]; end
      K_ROR:   begin r = (op >> n) | (op << hi);          co = op[lo]; end
      K_RRX:   begin r = {c, op[WIDTH-1:1]};              co = op[0];  end
      default: ;
    endcase
    return {co, r};
  endfunction

  // Saturated shifts are resolved here and then spend one idle SHIFT cycle (K_NONE).
  always_comb begin
    dec_op   = bus.rm;
    dec_kind = K_NONE;
    dec_amt  = '0;
    dec_c    = bus.c_in;
    sh_type  = bus.shift_operand[6:5];
    rot      = {bus.shift_operand[11:8], 1'b0};
    amt_a    = '0;
    if (bus.is_mem_command) begin
      dec_op = WIDTH'(bus.shift_operand);
    end else if (bus.immd) begin
      dec_op = WIDTH'(bus.shift_operand[7:0]);
      if (rot != 5'd0) begin
        if (LW'(rot) == '0) begin
          dec_c = dec_op[WIDTH-1];
        end else begin
          dec_kind = K_ROR;
          dec_amt  = LW'(rot);
        end
      end
    end else begin
      if (bus.reg_shift) begin
        amt_a = {{(AW-8){1'b0}}, bus.rs[7:0]};
      end else begin
        amt_a = AW'(bus.shift_operand[11:7]);
        if (amt_a == '0 && (sh_type == 2'b01 || sh_type == 2'b10)) amt_a = AW'(WIDTH);
      end
      if (!bus.reg_shift && amt_a == '0 && sh_type == 2'b11) begin
        dec_kind = K_RRX;
        dec_amt  = LW'(1);
      end else if (amt_a != '0) begin
        case (sh_type)
          2'b00: begin
            if (amt_a < AW'(WIDTH)) begin
              dec_kind = K_LSL;
              dec_amt  = amt_a[LW-1:0];
            end else begin
              dec_op  = '0;
              dec_c   = (amt_a == AW'(WIDTH)) ? bus.rm[0] : 1'b0;
              dec_amt = LW'(1);
            end
          end
          2'b01: begin
            if (amt_a < AW'(WIDTH)) begin
              dec_kind = K_LSR;
              dec_amt  = amt_a[LW-1:0];
            end else begin
              dec_op  = '0;
              dec_c   = (amt_a == AW'(WIDTH)) ? bus.rm[WIDTH-1] : 1'b0;
              dec_amt = LW'(1);
            end
          end
          2'b10: begin
            if (amt_a < AW'(WIDTH)) begin
              dec_kind = K_ASR;
              dec_amt  = amt_a[LW-1:0];
            end else begin
              dec_op  = {WIDTH{bus.rm[WIDTH-1]}};
              dec_c   = bus.rm[WIDTH-1];
              dec_amt = LW'(1);
            end
          end
          default: begin
            if (amt_a[LW-1:0] == '0) begin
              dec_c = bus.rm[WIDTH-1];
            end else begin
              dec_kind = K_ROR;
              dec_amt  = amt_a[LW-1:0];
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    if ({1'b0, rem_q} > (LW+1)'(STEP)) step_n = LW'(STEP);
    else                               step_n = rem_q;
    {step_c, step_r} = shift_step(kind_q, op_q, step_n, c_q);
  end

`ifdef VAL2_ZERO_LATENCY_EN
  logic             zl_ok;
  logic             zl_fire;
  logic [WIDTH-1:0] zl_r;
  logic             zl_c;

  assign zl_ok   = ({1'b0, dec_amt} <= (LW+1)'(STEP));
  assign zl_fire = (state_q == S_IDLE) && bus.in_valid && zl_ok;
  assign {zl_c, zl_r} = shift_step(dec_kind, dec_op, dec_amt, dec_c);

  assign bus.out_valid = out_valid_q | zl_fire;
  assign bus.val2_out  = zl_fire ? zl_r : val2_q;
  assign bus.carry_out = zl_fire ? zl_c : carry_q;
`else
  assign bus.out_valid = out_valid_q;
  assign bus.val2_out  = val2_q;
  assign bus.carry_out = carry_q;
`endif
  assign bus.in_ready = in_ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      val2_q      <= '0;
      carry_q     <= 1'b0;
      op_q        <= '0;
      rem_q       <= '0;
      kind_q      <= K_NONE;
      c_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
`ifdef VAL2_ZERO_LATENCY_EN
            if (zl_ok) begin
              if (!bus.out_ready) begin
                state_q     <= S_DONE;
                val2_q      <= zl_r;
                carry_q     <= zl_c;
                out_valid_q <= 1'b1;
                in_ready_q  <= 1'b0;
              end
            end else
`endif
            if (dec_amt == '0) begin
              state_q     <= S_DONE;
              val2_q      <= dec_op;
              carry_q     <= dec_c;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end else begin
              state_q    <= S_SHIFT;
              op_q       <= dec_op;
              rem_q      <= dec_amt;
              kind_q     <= dec_kind;
              c_q        <= dec_c;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          op_q  <= step_r;
          c_q   <= step_c;
          rem_q <= rem_q - step_n;
          if (rem_q == step_n) begin
            state_q     <= S_DONE;
            val2_q      <= step_r;
            carry_q     <= step_c;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_val2_shift_engine.sv
// tb/tb_val2_shift_engine.sv - vector table, random model comparison and handshake/reset sequences
module tb_val2_shift_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  val2_shift_engine_if #(.WIDTH(32)) bus ();
  val2_shift_engine #(.WIDTH(32), .STEP(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rm;
    logic [31:0] rs;
    logic [11:0] so;
    logic        immd;
    logic        rsh;
    logic        mem;
    logic        c;
    logic [31:0] v;
    logic        co;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int m);
    if (m == 0) return x;
    return (x >> m) | (x << (32 - m));
  endfunction

  // Reference: direct arithmetic on the whole shift amount, then latency from the amount.
  function automatic void model(input logic [31:0] rm, input logic [31:0] rs, input logic [11:0] so,
                                input logic immd, input logic rsh, input logic mem, input logic c,
                                output logic [31:0] v, output logic co, output int lat);
    int               a;
    int               eff;
    logic [1:0]       typ;
    logic [63:0]      t;
    logic signed [63:0] ts;
    v   = rm;
    co  = c;
    eff = 0;
    typ = so[6:5];
    if (mem) begin
      v = {20'b0, so};
    end else if (immd) begin
      a  = 2 * int'(so[11:8]);
      v  = rotr({24'b0, so[7:0]}, a);
      co = (a == 0) ? c : v[31];
      eff = a;
    end else begin
      a = rsh ? int'(rs[7:0]) : int'(so[11:7]);
      if (!rsh && a == 0 && typ == 2'b11) begin
        v = {c, rm[31:1]}; co = rm[0]; eff = 1;
      end else begin
        if (!rsh && a == 0 && (typ == 2'b01 || typ == 2'b10)) a = 32;
        if (a != 0) begin
          case (typ)
            2'b00: if (a < 32) begin t = {32'b0, rm} << a; v = t[31:0]; co = t[32]; eff = a; end
                   else begin v = 0; co = (a == 32) ? rm[0] : 1'b0; eff = 1; end
            2'b01: if (a < 32) begin t = {rm, 32'b0} >> a; v = t[63:32]; co = t[31]; eff = a; end
                   else begin v = 0; co = (a == 32) ? rm[31] : 1'b0; eff = 1; end
            2'b10: if (a < 32) begin ts = $signed({rm, 32'b0}) >>> a; v = ts[63:32]; co = ts[31]; eff = a; end
                   else begin v = {32{rm[31]}}; co = rm[31]; eff = 1; end
            default: if (a % 32 == 0) begin v = rm; co = rm[31]; eff = 0; end
                     else begin v = rotr(rm, a % 32); co = v[31]; eff = a % 32; end
          endcase
        end
      end
    end
    lat = 1 + (eff + 3) / 4;
  endfunction

  task automatic run_req(input logic [31:0] a_rm, input logic [31:0] a_rs, input logic [11:0] a_so,
                         input logic a_im, input logic a_rsh, input logic a_mem, input logic a_c,
                         input int hold, output logic [31:0] v, output logic co, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.rm = a_rm; bus.rs = a_rs; bus.shift_operand = a_so;
    bus.immd = a_im; bus.reg_shift = a_rsh; bus.is_mem_command = a_mem; bus.c_in = a_c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    v  = bus.val2_out;
    co = bus.carry_out;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] gv, ev, r_rm, r_rs;
    logic        gc, ec, r_im, r_rsh, r_mem, r_c, seen;
    logic [11:0] r_so;
    int          gl, el, pick, a, lat;

    vecs[0]  = '{32'h0,        32'h0,        12'hABC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000ABC, 1'b1, 1};
    vecs[1]  = '{32'h0,        32'h0,        12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFF000000, 1'b1, 3};
    vecs[2]  = '{32'h80000001, 32'h0,        12'h020, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 2};
    vecs[3]  = '{32'h80000001, 32'h0,        12'h040, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 2};
    vecs[4]  = '{32'h00000003, 32'h0,        12'h060, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000001, 1'b1, 2};
    vecs[5]  = '{32'h00000001, 32'd32,       12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{32'h80000000, 32'd33,       12'h030, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 2};
    vecs[7]  = '{32'h80000000, 32'd64,       12'h070, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b1, 1};
    vecs[8]  = '{32'h0F000001, 32'h0,        12'h280, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE0000020, 1'b1, 3};
    vecs[9]  = '{32'h12345678, 32'h0,        12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1};
    vecs[10] = '{32'h7FFFFFFF, 32'd200,      12'h050, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 2};
    vecs[11] = '{32'h12345678, 32'hABCDEF04, 12'h070, 1'b0, 1'b1, 1'b0, 1'b0, 32'h81234567, 1'b1, 2};
    vecs[12] = '{32'h0,        32'h0,        12'h0AB, 1'b1, 1'b0, 1'b0, 1'b1, 32'h000000AB, 1'b1, 1};
    vecs[13] = '{32'h00000005, 32'h0,        12'h030, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000005, 1'b0, 1};
    vecs[14] = '{32'h00000003, 32'd31,       12'h010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b1, 9};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.rm = '0; bus.rs = '0;
    bus.shift_operand = '0; bus.immd = 1'b0; bus.reg_shift = 1'b0;
    bus.is_mem_command = 1'b0; bus.c_in = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("reset_val2", 0, bus.val2_out, 32'd0);
    chk("reset_carry", 0, 32'(bus.carry_out), 32'd0);

    for (int i = 0; i < 15; i++) begin
      run_req(vecs[i].rm, vecs[i].rs, vecs[i].so, vecs[i].immd, vecs[i].rsh, vecs[i].mem,
              vecs[i].c, 0, gv, gc, gl);
      chk("vec_val2", i, gv, vecs[i].v);
      chk("vec_carry", i, 32'(gc), 32'(vecs[i].co));
      chk("vec_latency", i, gl, vecs[i].lat);
    end

    for (int i = 0; i < 300; i++) begin
      pick  = int'($urandom_range(0, 9));
      r_rm  = $urandom();
      if (pick == 5) r_rm = r_rm | 32'h80000000;
      r_so  = 12'($urandom());
      r_mem = (pick == 0);
      r_im  = (pick == 1 || pick == 2);
      r_rsh = 1'($urandom());
      r_c   = 1'($urandom());
      a     = (pick >= 7) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      r_rs  = ($urandom() & 32'hFFFFFF00) | 32'(a);
      model(r_rm, r_rs, r_so, r_im, r_rsh, r_mem, r_c, ev, ec, el);
      run_req(r_rm, r_rs, r_so, r_im, r_rsh, r_mem, r_c, int'($urandom_range(0, 2)), gv, gc, gl);
      chk("rnd_val2", i, gv, ev);
      chk("rnd_carry", i, 32'(gc), 32'(ec));
      chk("rnd_latency", i, gl, el);
    end

    // Backpressure in DONE while a different request is held on the input.
    bus.rm = '0; bus.rs = '0; bus.shift_operand = 12'h4FF; bus.immd = 1'b1;
    bus.reg_shift = 1'b0; bus.is_mem_command = 1'b0; bus.c_in = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.immd = 1'b0; bus.is_mem_command = 1'b1; bus.shift_operand = 12'h123;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 0, lat, 3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_val2", k, bus.val2_out, 32'hFF000000);
      chk("bp_carry", k, 32'(bus.carry_out), 32'd1);
      chk("bp_in_ready", k, 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", k, 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_no_same_cycle_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("hs_idle_ready", 0, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("held_req_valid", 0, 32'(bus.out_valid), 32'd1);
    chk("held_req_val2", 0, bus.val2_out, 32'h00000123);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while shifting: LSL by 20 needs five SHIFT cycles.
    bus.rm = 32'h1; bus.rs = 32'd20; bus.shift_operand = 12'h010; bus.immd = 1'b0;
    bus.reg_shift = 1'b1; bus.is_mem_command = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy_ready", 0, 32'(bus.in_ready), 32'd0);
    chk("pre_rst_busy_valid", 0, 32'(bus.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    chk("rst_val2", 0, bus.val2_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_no_result", 0, 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
